// File: rtl/result_argmax.sv
// Serial argmax over a snapshot of N signed class scores.
// One score is examined per cycle; the winner is reported with a one-cycle VALID pulse.
module result_argmax #(
  parameter int N  = 46,
  parameter int W  = 32,
  parameter int IW = 6
) (
  input  logic            CLK,
  input  logic            RESET_X,
  input  logic            START,
  input  logic [N*W-1:0]  SCORES,
  output logic            BUSY,
  output logic            VALID,
  output logic [IW-1:0]   CLASS,
  output logic [W-1:0]    MAX_VAL
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [W-1:0]        snap [N];
  logic [IW-1:0]       idx;
  logic signed [W-1:0] run_max;
  logic [IW-1:0]       run_idx;
  logic signed [W-1:0] cur;
  logic                last;
  logic signed [W-1:0] best_val;
  logic [IW-1:0]       best_idx;

  // Element 0 seeds the running max; later elements must be strictly greater,
  // so ties stay with the lower index.
  always_comb begin
    cur      = snap[idx];
    last     = (idx == IW'(N - 1));
    best_val = run_max;
    best_idx = run_idx;
    if ((idx == '0) || (cur > run_max)) begin
      best_val = cur;
      best_idx = idx;
    end
  end

  always_ff @(posedge CLK or negedge RESET_X) begin
    if (!RESET_X) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (START) state_nxt = SCAN;
      SCAN:    if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_X) begin
    if (!RESET_X) begin
      for (int i = 0; i < N; i++) snap[i] <= '0;
      idx     <= '0;
      run_max <= '0;
      run_idx <= '0;
      VALID   <= 1'b0;
      CLASS   <= '0;
      MAX_VAL <= '0;
    end else begin
      VALID <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            for (int i = 0; i < N; i++) snap[i] <= SCORES[i*W +: W];
            idx <= '0;
          end
        end
        SCAN: begin
          run_max <= best_val;
          run_idx <= best_idx;
          if (last) begin
            CLASS   <= best_idx;
            MAX_VAL <= best_val;
            VALID   <= 1'b1;
            idx     <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign BUSY = (state == SCAN);

endmodule

// File: tb/tb_result_argmax.sv
// Self-checking bench for result_argmax: directed corner cases plus randomized
// score sets compared against a plain argmax model.
module tb_result_argmax;
  localparam int N  = 46;
  localparam int W  = 32;
  localparam int IW = 6;

  logic            CLK;
  logic            RESET_X;
  logic            START;
  logic [N*W-1:0]  SCORES;
  logic            BUSY;
  logic            VALID;
  logic [IW-1:0]   CLASS;
  logic [W-1:0]    MAX_VAL;

  int checks   = 0;
  int failures = 0;
  int sc [N];

  result_argmax #(.N(N), .W(W), .IW(IW)) dut (
    .CLK(CLK), .RESET_X(RESET_X), .START(START), .SCORES(SCORES),
    .BUSY(BUSY), .VALID(VALID), .CLASS(CLASS), .MAX_VAL(MAX_VAL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic pack_scores();
    for (int i = 0; i < N; i++) SCORES[i*W +: W] = sc[i];
  endtask

  // Reference: first index holding the largest signed value.
  task automatic model(output logic [IW-1:0] c, output logic [W-1:0] m);
    int best = sc[0];
    int bi = 0;
    for (int i = 1; i < N; i++)
      if (sc[i] > best) begin best = sc[i]; bi = i; end
    c = IW'(bi);
    m = best;
  endtask

  task automatic fill_random(input bit narrow);
    for (int i = 0; i < N; i++)
      sc[i] = narrow ? (int'($urandom_range(0, 15)) - 8) : int'($urandom);
  endtask

  // Pulse START for one edge and wait (bounded) for the VALID pulse.
  task automatic run_scan(output int lat, output int busy_cnt,
                          output logic [IW-1:0] cls, output logic [W-1:0] mx);
    pack_scores();
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
    lat = 0; busy_cnt = 0;
    while (!VALID && lat < 200) begin
      if (BUSY) busy_cnt++;
      @(negedge CLK);
      lat++;
    end
    cls = CLASS;
    mx  = MAX_VAL;
  endtask

  task automatic test_reset();
    RESET_X = 1'b0; START = 1'b0; SCORES = '0;
    #3;
    checks++;
    if ({BUSY, VALID} !== 2'b00) begin
      failures++; $display("[TB] FAIL reset_flags got=%b exp=00", {BUSY, VALID});
    end
    checks++;
    if ({CLASS, MAX_VAL} !== '0) begin
      failures++; $display("[TB] FAIL reset_outputs class=%0d max=%0d exp=0/0", CLASS, $signed(MAX_VAL));
    end
    repeat (2) @(negedge CLK);
    RESET_X = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_distinct_max();
    int lat, bc; logic [IW-1:0] c; logic [W-1:0] m;
    for (int i = 0; i < N; i++) sc[i] = i * 10 - 200;
    sc[17] = 5000;
    run_scan(lat, bc, c, m);
    checks++;
    if (lat !== N) begin failures++; $display("[TB] FAIL distinct_latency got=%0d exp=%0d", lat, N); end
    checks++;
    if (bc !== N) begin failures++; $display("[TB] FAIL distinct_busy_cycles got=%0d exp=%0d", bc, N); end
    checks++;
    if (BUSY !== 1'b0) begin failures++; $display("[TB] FAIL distinct_busy_at_valid got=%b exp=0", BUSY); end
    checks++;
    if (c !== 6'd17 || m !== 32'd5000) begin
      failures++; $display("[TB] FAIL distinct_result got=%0d/%0d exp=17/5000", c, $signed(m));
    end
    @(negedge CLK);
    checks++;
    if (VALID !== 1'b0) begin failures++; $display("[TB] FAIL distinct_valid_pulse got=%b exp=0", VALID); end
  endtask

  task automatic test_boundaries();
    int lat, bc; logic [IW-1:0] c; logic [W-1:0] m;
    for (int i = 0; i < N; i++) sc[i] = 0;
    sc[3] = 7; sc[40] = 7;
    run_scan(lat, bc, c, m);
    checks++;
    if (c !== 6'd3 || m !== 32'd7) begin failures++; $display("[TB] FAIL tie_low_index got=%0d/%0d exp=3/7", c, $signed(m)); end

    for (int i = 0; i < N; i++) sc[i] = -1;
    sc[0] = 100;
    run_scan(lat, bc, c, m);
    checks++;
    if (c !== 6'd0 || m !== 32'd100) begin failures++; $display("[TB] FAIL max_at_first got=%0d/%0d exp=0/100", c, $signed(m)); end

    for (int i = 0; i < N; i++) sc[i] = -1;
    sc[45] = 100;
    run_scan(lat, bc, c, m);
    checks++;
    if (c !== 6'd45 || m !== 32'd100) begin failures++; $display("[TB] FAIL max_at_last got=%0d/%0d exp=45/100", c, $signed(m)); end
  endtask

  task automatic test_extremes();
    int lat, bc; logic [IW-1:0] c; logic [W-1:0] m;
    for (int i = 0; i < N; i++) sc[i] = 32'h8000_0000;
    sc[9] = 32'hFFFF_FFFF;
    run_scan(lat, bc, c, m);
    checks++;
    if (c !== 6'd9 || m !== 32'hFFFF_FFFF) begin
      failures++; $display("[TB] FAIL all_negative got=%0d/%0d exp=9/-1", c, $signed(m));
    end
    for (int i = 0; i < N; i++) sc[i] = 32'h8000_0000;
    sc[22] = 32'h7FFF_FFFF;
    run_scan(lat, bc, c, m);
    checks++;
    if (c !== 6'd22 || m !== 32'h7FFF_FFFF) begin
      failures++; $display("[TB] FAIL full_range got=%0d/%0d exp=22/2147483647", c, $signed(m));
    end
  endtask

  task automatic test_snapshot_ignore();
    logic [IW-1:0] ec, c; logic [W-1:0] em, m;
    int pulses = 0;
    int lat = 0;
    fill_random(1'b1);
    sc[30] = 0;
    model(ec, em);
    pack_scores();
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
    c = '0; m = '0;
    for (int t = 0; t <= N + 15; t++) begin
      if (t == 4) begin
        sc[30] = 32'h7FFF_FFFF;
        pack_scores();
        START = 1'b1;
      end
      if (t == 5) START = 1'b0;
      if (VALID) begin
        pulses++;
        if (pulses == 1) begin lat = t; c = CLASS; m = MAX_VAL; end
      end
      @(negedge CLK);
    end
    checks++;
    if (pulses !== 1) begin failures++; $display("[TB] FAIL ignore_pulse_count got=%0d exp=1", pulses); end
    checks++;
    if (lat !== N) begin failures++; $display("[TB] FAIL ignore_latency got=%0d exp=%0d", lat, N); end
    checks++;
    if (c !== ec || m !== em) begin
      failures++; $display("[TB] FAIL snapshot_result got=%0d/%0d exp=%0d/%0d", c, $signed(m), ec, $signed(em));
    end
  endtask

  task automatic test_back_to_back();
    localparam int RUNS = 4;
    logic [IW-1:0] ec [RUNS];
    logic [W-1:0]  em [RUNS];
    int cyc;
    fill_random(1'b0);
    model(ec[0], em[0]);
    pack_scores();
    @(negedge CLK); START = 1'b1;
    for (int r = 0; r < RUNS; r++) begin
      @(negedge CLK);
      cyc = 1;
      if (r > 0) begin
        checks++;
        if (VALID !== 1'b0) begin failures++; $display("[TB] FAIL b2b_valid_drop run=%0d got=%b exp=0", r, VALID); end
      end
      if (r + 1 < RUNS) begin
        fill_random(r[0]);
        model(ec[r+1], em[r+1]);
        pack_scores();
      end else begin
        START = 1'b0;
      end
      while (!VALID && cyc < 200) begin @(negedge CLK); cyc++; end
      checks++;
      if (cyc !== N + 1) begin failures++; $display("[TB] FAIL b2b_spacing run=%0d got=%0d exp=%0d", r, cyc, N + 1); end
      checks++;
      if (CLASS !== ec[r] || MAX_VAL !== em[r]) begin
        failures++;
        $display("[TB] FAIL b2b_result run=%0d got=%0d/%0d exp=%0d/%0d", r, CLASS, $signed(MAX_VAL), ec[r], $signed(em[r]));
      end
    end
    @(negedge CLK);
  endtask

  task automatic test_random();
    int lat, bc; logic [IW-1:0] c, ec; logic [W-1:0] m, em;
    for (int k = 0; k < 6; k++) begin
      fill_random(k[0]);
      model(ec, em);
      run_scan(lat, bc, c, m);
      checks++;
      if (lat !== N || c !== ec || m !== em) begin
        failures++;
        $display("[TB] FAIL random_%0d got=%0d/%0d lat=%0d exp=%0d/%0d lat=%0d", k, c, $signed(m), lat, ec, $signed(em), N);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    int lat, bc, seen; logic [IW-1:0] c, ec; logic [W-1:0] m, em;
    fill_random(1'b1);
    sc[33] = 1000;
    run_scan(lat, bc, c, m);
    checks++;
    if (c !== 6'd33 || m !== 32'd1000) begin failures++; $display("[TB] FAIL pre_reset_result got=%0d/%0d exp=33/1000", c, $signed(m)); end
    fill_random(1'b0);
    pack_scores();
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
    repeat (20) @(negedge CLK);
    RESET_X = 1'b0;
    #1;
    checks++;
    if ({BUSY, VALID} !== 2'b00 || CLASS !== '0 || MAX_VAL !== '0) begin
      failures++;
      $display("[TB] FAIL midscan_reset got busy=%b valid=%b class=%0d max=%0d exp=0/0/0/0", BUSY, VALID, CLASS, $signed(MAX_VAL));
    end
    repeat (3) @(negedge CLK);
    RESET_X = 1'b1;
    seen = 0;
    for (int t = 0; t < N + 5; t++) begin
      @(negedge CLK);
      if (VALID) seen++;
    end
    checks++;
    if (seen !== 0) begin failures++; $display("[TB] FAIL aborted_scan_valid got=%0d exp=0", seen); end
    model(ec, em);
    run_scan(lat, bc, c, m);
    checks++;
    if (lat !== N || c !== ec || m !== em) begin
      failures++;
      $display("[TB] FAIL post_reset_scan got=%0d/%0d lat=%0d exp=%0d/%0d lat=%0d", c, $signed(m), lat, ec, $signed(em), N);
    end
  endtask

  initial begin
    test_reset();
    test_distinct_max();
    test_boundaries();
    test_extremes();
    test_snapshot_ignore();
    test_back_to_back();
    test_random();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog_timeout");
    $fatal(1, "[TB] simulation did not terminate");
  end

endmodule
